shift_rx_fsm: RTL and testbench
===============================

SHIFT_RX_FSM -- requirements
Module: shift_rx_fsm

Interface
REQ-001 SHALL have parameter SOURCE_CLK, default 12000000, meaning hwclk frequency in Hz.
REQ-002 SHALL have parameter TARGET_CLK, default 9600, meaning baud rate (4800, 9600 or 115200 supported).
REQ-003 SHALL have parameter OVERSAMPLE, default 16, meaning sample ticks per bit.
REQ-004 SHALL have parameter FRAME_WIDTH, default 8, meaning data bits per frame.
REQ-005 SHALL have port hwclk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, meaning synchronous active-low reset.
REQ-007 SHALL have port ftdi_rx, input, 1, meaning asynchronous serial line, idle high, 8N1, LSB first.
REQ-008 SHALL have port data_frame, output, FRAME_WIDTH, meaning last correctly received byte.
REQ-009 SHALL have port frame_valid, output, 1, meaning one-cycle pulse when data_frame updates.
REQ-010 SHALL have port frame_err, output, 1, meaning one-cycle pulse on stop-bit error.
REQ-011 SHALL have port busy, output, 1, meaning high while in any state other than IDLE.

Function
REQ-012 SHALL pass ftdi_rx through a 2-flop synchronizer before any use; both flops reset to 1.
REQ-013 SHALL generate a one-hwclk-wide sample tick every DIV = SOURCE_CLK/(TARGET_CLK*OVERSAMPLE) cycles (integer truncation; 78 at defaults); the divider counter wraps from DIV-1 to 0.
REQ-014 SHALL hold the tick divider at 0 in IDLE and restart it from 0 on the cycle the start edge is detected, so bit phase is aligned to the edge.
REQ-015 SHALL implement states IDLE, START, DATA, STOP, BREAK.
REQ-016 In IDLE, a synchronized 1->0 transition SHALL move the block to START with the tick counter (0..OVERSAMPLE-1) cleared.
REQ-017 Each bit SHALL be decided by a 2-of-3 majority of samples taken at tick counts OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 (7, 8 and 9 at defaults).
REQ-018 In START, a majority of 1 SHALL be treated as a false start: return to IDLE with no pulse; a majority of 0 SHALL move the block to DATA at tick count wrap.
REQ-019 In DATA, each decided bit SHALL shift into the MSB of the shift register (LSB-first reception); after FRAME_WIDTH bits the block SHALL move to STOP.
REQ-020 In STOP, on the decision tick: if the majority is 1, data_frame SHALL load the shift register, frame_valid SHALL pulse on the next hwclk cycle, and the state SHALL return to IDLE immediately (mid-stop-bit) so that back-to-back frames are accepted.
REQ-021 In STOP, a majority of 0 SHALL pulse frame_err, leave data_frame unchanged, and move the block to BREAK.
REQ-022 BREAK SHALL remain until the synchronized line reads 1, then move to IDLE; no start edge is accepted while in BREAK.
REQ-023 frame_valid and frame_err SHALL never be asserted in the same cycle, and each SHALL be exactly one hwclk cycle wide.
REQ-024 Latency SHALL be such that frame_valid rises one hwclk cycle after the sample tick at count OVERSAMPLE/2+1 of the stop bit.

Reset
REQ-025 While rst_n=0 at a rising hwclk: state=IDLE; counters=0; shift register=0; data_frame=0; frame_valid=0; frame_err=0; busy=0; synchronizer flops=1.
REQ-026 A reset asserted mid-frame SHALL abort the frame with no pulse; after release, a start bit is recognised only on a fresh 1->0 edge.

Structure
REQ-027 State encoding, OVERSAMPLE and the DIV computation SHALL live in a shared shift_uart_pkg include, which shift_tx_fsm also uses.
REQ-028 The tick divider SHALL be a sub-module, rx_tick_gen (ports hwclk, rst_n, clr, tick), instantiated once.

Verification
REQ-029 Test: at defaults, send 0x48 (stop=1) at 9600 baud -> exactly one frame_valid, data_frame=0x48, frame_err never asserted.
REQ-030 Test: send 0x55 then 0xAA back-to-back with no idle gap -> two frame_valid pulses, values 0x55 then 0xAA.
REQ-031 Test: drive a 20-cycle low glitch on an idle line -> back to IDLE within one bit time; no frame_valid and no frame_err.
REQ-032 Test: send 0x3C with stop bit=0, hold the line low for 3 bit times, then release -> one frame_err, data_frame keeps its previous value, busy stays high until the line goes high.
REQ-033 Test: invert only the tick-8 sample of every data bit while sending 0xA5 -> the majority vote recovers 0xA5 with frame_valid.
REQ-034 Test: assert rst_n=0 during bit 4 of a frame, release, then send 0x12 -> no pulse for the aborted frame; then 0x12 is received correctly.

Source files
------------

// File: rtl/shift_uart_pkg.sv
// Definitions shared by the UART receive and transmit state machines:
// state encoding, default oversampling and the sample-tick divider formula.
package shift_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

  localparam int unsigned UART_OVERSAMPLE = 16;

  // Truncating divide; clamped to 1 so a too-fast baud still yields a legal divider.
  function automatic int unsigned uart_div(input int unsigned src_clk,
                                           input int unsigned baud,
                                           input int unsigned os);
    int unsigned d;
    d = src_clk / (baud * os);
    if (d == 0) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/rx_tick_gen.sv
// Sample-tick divider: one-cycle tick every DIV clocks, held at zero while clr is high
// so that the first tick after release lands exactly DIV cycles later.
module rx_tick_gen
  import shift_uart_pkg::*;
#(
  parameter int unsigned DIV = 78
) (
  input  logic hwclk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge hwclk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = !clr && (cnt_q == LAST);

endmodule

// File: rtl/shift_rx_fsm.sv
// 8N1 UART receiver: synchronised line, edge-aligned oversampling, 2-of-3 majority per bit,
// valid/error pulses on the stop-bit decision and a BREAK state for a held-low line.
module shift_rx_fsm
  import shift_uart_pkg::*;
#(
  parameter int unsigned SOURCE_CLK  = 12000000,
  parameter int unsigned TARGET_CLK  = 9600,
  parameter int unsigned OVERSAMPLE  = UART_OVERSAMPLE,
  parameter int unsigned FRAME_WIDTH = 8
) (
  input  logic                   hwclk,
  input  logic                   rst_n,
  input  logic                   ftdi_rx,
  output logic [FRAME_WIDTH-1:0] data_frame,
  output logic                   frame_valid,
  output logic                   frame_err,
  output logic                   busy
);

  localparam int unsigned DIV = uart_div(SOURCE_CLK, TARGET_CLK, OVERSAMPLE);
  localparam int unsigned OW  = $clog2(OVERSAMPLE);
  localparam int unsigned BW  = $clog2(FRAME_WIDTH + 1);

  localparam logic [OW-1:0] T_S0   = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [OW-1:0] T_S1   = OW'(OVERSAMPLE / 2);
  localparam logic [OW-1:0] T_DEC  = OW'(OVERSAMPLE / 2 + 1);
  localparam logic [OW-1:0] T_LAST = OW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(FRAME_WIDTH);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  uart_state_e            state_q;
  logic                   sync1_q, sync2_q, prev_q;
  logic [OW-1:0]          os_q;
  logic [BW-1:0]          bit_q;
  logic                   samp0_q, samp1_q;
  logic [FRAME_WIDTH-1:0] shift_q, data_q;
  logic                   valid_q, err_q;

  logic rx_s, fall, tick, clr, vote;

  assign rx_s = sync2_q;
  assign fall = prev_q & ~sync2_q;
  assign clr  = (state_q == ST_IDLE) || (state_q == ST_BREAK);
  assign vote = maj3(samp0_q, samp1_q, rx_s);

  rx_tick_gen #(.DIV(DIV)) u_tick (
    .hwclk (hwclk),
    .rst_n (rst_n),
    .clr   (clr),
    .tick  (tick)
  );

  always_ff @(posedge hwclk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      os_q    <= '0;
      bit_q   <= '0;
      samp0_q <= 1'b1;
      samp1_q <= 1'b1;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync1_q <= ftdi_rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      valid_q <= 1'b0;
      err_q   <= 1'b0;

      if (tick) begin
        if (os_q == T_S0) samp0_q <= rx_s;
        if (os_q == T_S1) samp1_q <= rx_s;
        os_q <= (os_q == T_LAST) ? '0 : os_q + 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          os_q  <= '0;
          bit_q <= '0;
          if (fall) state_q <= ST_START;
        end
        ST_START: begin
          if (tick && (os_q == T_DEC) && vote) state_q <= ST_IDLE;
          else if (tick && (os_q == T_LAST))   state_q <= ST_DATA;
        end
        ST_DATA: begin
          if (tick && (os_q == T_DEC)) begin
            shift_q <= {vote, shift_q[FRAME_WIDTH-1:1]};
            bit_q   <= bit_q + 1'b1;
          end
          if (tick && (os_q == T_LAST) && (bit_q == B_LAST)) begin
            bit_q   <= '0;
            state_q <= ST_STOP;
          end
        end
        ST_STOP: begin
          // Leave mid-stop-bit so a start edge right after it is still caught.
          if (tick && (os_q == T_DEC)) begin
            if (vote) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              err_q   <= 1'b1;
              state_q <= ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          if (rx_s) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign data_frame  = data_q;
  assign frame_valid = valid_q;
  assign frame_err   = err_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shift_rx_fsm.sv
// Directed bench for shift_rx_fsm: frames are driven bit by bit and a queue of expected
// bytes with their expected pulse cycle is checked against the outputs every cycle.
module tb_shift_rx_fsm;

  localparam int SRC  = 2457600;
  localparam int BAUD = 9600;
  localparam int OS   = 16;
  localparam int FW   = 8;
  localparam int DIVB = SRC / (BAUD * OS);
  localparam int BIT  = DIVB * OS;
  // line fall -> valid pulse: 3 cycles of sync/edge, then tick count OS/2+1 of the stop bit, +1 register
  localparam int LAT  = 3 + (OS * (FW + 1) + OS / 2 + 2) * DIVB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ftdi_rx = 1'b1;
  logic [FW-1:0] data_frame;
  logic          frame_valid, frame_err, busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [FW-1:0] exp_data[$];
  int            exp_t[$];
  int            exp_err = 0;
  logic [FW-1:0] model_last = '0;
  logic          rst_at_edge = 1'b0;
  logic          prev_valid = 1'b0;
  logic          prev_err = 1'b0;

  shift_rx_fsm #(
    .SOURCE_CLK (SRC),
    .TARGET_CLK (BAUD),
    .OVERSAMPLE (OS),
    .FRAME_WIDTH(FW)
  ) dut (
    .hwclk      (clk),
    .rst_n      (rst_n),
    .ftdi_rx    (ftdi_rx),
    .data_frame (data_frame),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst_n;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_at_edge) begin
      chk("reset_outputs", {21'd0, data_frame, frame_valid, frame_err, busy}, 32'd0);
      model_last = '0;
    end else begin
      if (frame_valid) begin
        chk("valid_err_excl", frame_err, 1'b0);
        chk("valid_width", prev_valid, 1'b0);
        tests++;
        if (exp_data.size() == 0) begin
          fails++;
          $display("FAIL valid_unexpected: got pulse with %0h, required none (cycle %0d)", data_frame, cyc);
        end else begin
          model_last = exp_data.pop_front();
          chk("valid_time", cyc, exp_t.pop_front());
        end
      end
      if (frame_err) begin
        chk("err_width", prev_err, 1'b0);
        tests++;
        if (exp_err == 0) begin
          fails++;
          $display("FAIL err_unexpected: got frame_err, required none (cycle %0d)", cyc);
        end else begin
          exp_err--;
        end
      end
      chk("data_frame", data_frame, model_last);
    end
    prev_valid = frame_valid;
    prev_err   = frame_err;
  end

  task automatic idle(input int n);
    ftdi_rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // abort_bit >= 0: pull reset in the middle of that data bit and drop the frame.
  task automatic send_frame(input logic [FW-1:0] d, input bit stop_ok, input bit flip8,
                            input int abort_bit, input int stop_cycles);
    logic [FW+1:0] bits;
    int len;
    bits = {stop_ok, d, 1'b0};
    for (int j = 0; j < FW + 2; j++) begin
      len = (j == FW + 1) ? stop_cycles : BIT;
      for (int c = 0; c < len; c++) begin
        @(posedge clk);
        #1;
        if (j == 0 && c == 0 && abort_bit < 0) begin
          if (stop_ok) begin
            exp_data.push_back(d);
            exp_t.push_back(cyc + LAT);
          end else begin
            exp_err++;
          end
        end
        if (abort_bit >= 0 && j == abort_bit + 1 && c == BIT / 2) begin
          rst_n   = 1'b0;
          ftdi_rx = 1'b1;
          repeat (20) @(posedge clk);
          #1;
          rst_n = 1'b1;
          return;
        end
        // the tick-8 sample sees the line about 144 cycles into each bit
        if (flip8 && j >= 1 && j <= FW && c >= 138 && c <= 150) ftdi_rx = ~bits[j];
        else                                                     ftdi_rx = bits[j];
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    ftdi_rx = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_data", data_frame, 8'h00);
    rst_n = 1'b1;
    idle(50);

    // single frame
    send_frame(8'h48, 1'b1, 1'b0, -1, BIT);
    idle(64);
    chk("t1_data", data_frame, 8'h48);
    chk("t1_drained", exp_data.size(), 0);
    chk("t1_busy", busy, 1'b0);

    // back-to-back frames, no idle gap
    send_frame(8'h55, 1'b1, 1'b0, -1, BIT);
    send_frame(8'hAA, 1'b1, 1'b0, -1, BIT);
    idle(64);
    chk("t2_data", data_frame, 8'hAA);
    chk("t2_drained", exp_data.size(), 0);

    // short glitch is a false start
    ftdi_rx = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("t3_busy_start", busy, 1'b1);
    idle(BIT);
    chk("t3_busy_idle", busy, 1'b0);
    chk("t3_data", data_frame, 8'hAA);

    // bad stop bit, line held low for three bit times
    send_frame(8'h3C, 1'b0, 1'b0, -1, 3 * BIT);
    chk("t4_busy_break", busy, 1'b1);
    chk("t4_err_seen", exp_err, 0);
    idle(6);
    chk("t4_busy_idle", busy, 1'b0);
    chk("t4_data_kept", data_frame, 8'hAA);
    idle(64);

    // majority vote recovers a corrupted middle sample
    send_frame(8'hA5, 1'b1, 1'b1, -1, BIT);
    idle(64);
    chk("t5_data", data_frame, 8'hA5);
    chk("t5_drained", exp_data.size(), 0);

    // reset during data bit 4, then a clean frame
    send_frame(8'h6B, 1'b1, 1'b0, 4, BIT);
    idle(64);
    chk("t6_busy", busy, 1'b0);
    chk("t6_data_reset", data_frame, 8'h00);
    send_frame(8'h12, 1'b1, 1'b0, -1, BIT);
    idle(64);
    chk("t6_data", data_frame, 8'h12);

    chk("end_valid_drained", exp_data.size(), 0);
    chk("end_err_drained", exp_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
